// File: rtl/alu_share_arbiter.sv
// Round-robin arbiter sharing one combinational ALU between two requesters, with a registered
// response buffer per requester. Define ALU_ARB_STATS_EN to add saturating grant counters.
module alu_share_arbiter #(
    parameter int unsigned WORD_W = 32,
    parameter int unsigned OP_W   = 4,
    parameter int unsigned CNT_W  = 16
) (
    input  logic              CLK,
    input  logic              nRST,

    input  logic              req0_valid,
    output logic              req0_ready,
    input  logic [OP_W-1:0]   req0_op,
    input  logic [WORD_W-1:0] req0_a,
    input  logic [WORD_W-1:0] req0_b,

    input  logic              req1_valid,
    output logic              req1_ready,
    input  logic [OP_W-1:0]   req1_op,
    input  logic [WORD_W-1:0] req1_a,
    input  logic [WORD_W-1:0] req1_b,

    output logic              rsp0_valid,
    input  logic              rsp0_ready,
    output logic [WORD_W-1:0] rsp0_result,
    output logic [2:0]        rsp0_flags,

    output logic              rsp1_valid,
    input  logic              rsp1_ready,
    output logic [WORD_W-1:0] rsp1_result,
    output logic [2:0]        rsp1_flags,

    output logic [OP_W-1:0]   alu_op,
    output logic [WORD_W-1:0] alu_port_a,
    output logic [WORD_W-1:0] alu_port_b,
    input  logic [WORD_W-1:0] alu_result,
    input  logic              alu_negative,
    input  logic              alu_overflow,
    input  logic              alu_zero
`ifdef ALU_ARB_STATS_EN
    ,
    output logic [CNT_W-1:0]  grant_cnt0,
    output logic [CNT_W-1:0]  grant_cnt1
`endif
);

    logic rr_ptr;
    logic elig0, elig1;
    logic grant0, grant1;

    // A full response buffer only blocks a new grant if it is not being drained this cycle.
    always_comb begin
        elig0  = req0_valid & (~rsp0_valid | rsp0_ready);
        elig1  = req1_valid & (~rsp1_valid | rsp1_ready);
        grant0 = elig0 & (~elig1 | ~rr_ptr);
        grant1 = elig1 & (~elig0 | rr_ptr);
    end

    assign req0_ready = grant0;
    assign req1_ready = grant1;

    always_comb begin
        alu_op     = '0;
        alu_port_a = '0;
        alu_port_b = '0;
        if (grant0) begin
            alu_op     = req0_op;
            alu_port_a = req0_a;
            alu_port_b = req0_b;
        end else if (grant1) begin
            alu_op     = req1_op;
            alu_port_a = req1_a;
            alu_port_b = req1_b;
        end
    end

    always_ff @(posedge CLK) begin
        if (!nRST) begin
            rr_ptr      <= 1'b0;
            rsp0_valid  <= 1'b0;
            rsp0_result <= '0;
            rsp0_flags  <= '0;
            rsp1_valid  <= 1'b0;
            rsp1_result <= '0;
            rsp1_flags  <= '0;
        end else begin
            if (grant0) begin
                rsp0_valid  <= 1'b1;
                rsp0_result <= alu_result;
                rsp0_flags  <= {alu_negative, alu_overflow, alu_zero};
            end else if (rsp0_ready) begin
                rsp0_valid  <= 1'b0;
            end

            if (grant1) begin
                rsp1_valid  <= 1'b1;
                rsp1_result <= alu_result;
                rsp1_flags  <= {alu_negative, alu_overflow, alu_zero};
            end else if (rsp1_ready) begin
                rsp1_valid  <= 1'b0;
            end

            // Priority passes to the other requester after each grant; idle cycles keep it.
            if (grant0) begin
                rr_ptr <= 1'b1;
            end else if (grant1) begin
                rr_ptr <= 1'b0;
            end
        end
    end

`ifdef ALU_ARB_STATS_EN
    always_ff @(posedge CLK) begin
        if (!nRST) begin
            grant_cnt0 <= '0;
            grant_cnt1 <= '0;
        end else begin
            if (grant0 && (grant_cnt0 != '1)) begin
                grant_cnt0 <= grant_cnt0 + CNT_W'(1);
            end
            if (grant1 && (grant_cnt1 != '1)) begin
                grant_cnt1 <= grant_cnt1 + CNT_W'(1);
            end
        end
    end
`endif

endmodule
